pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Reset and lock supervisor wrapped around the core PLL. Runs on the board reference clock and drives the PLL's active-high reset. It consumes the PLL `locked` flag and releases the system reset for the ARC4 datapath only after lock has been continuously stable. It re-resets the PLL on timeout or loss of lock, and latches a failure after repeated unsuccessful retries.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before reset release.
- `PLL_RST_CYCLES`, 16: width of each `pll_rst` pulse, in clk cycles.
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock after a PLL reset before retrying.
- `MAX_RETRIES`, 3: timeout retries allowed before the fail state.

Ports:
- `clk` in 1: board reference clock (50 MHz, same net as the PLL `refclk`).
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `pll_locked` in 1: PLL `locked`, asynchronous to `clk`.
- `pll_rst` out 1: to PLL `rst`, active high.
- `sys_rst_n` out 1: system reset for the downstream clock domain, active low. The consumer resynchronizes it into the PLL output domain.
- `ready` out 1: high while in RUN.
- `fail` out 1: sticky; high in FAIL.
- `loss_cnt` out 8: saturating count of lock losses seen in RUN.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`. Only `locked_s` is used.
- One counter `cnt` is shared by all states. Its width is `$clog2` of the largest of the three cycle parameters. It clears on every state change.
- A retry counter `retries` is `$clog2(MAX_RETRIES+1)` bits wide.
- States:
  - **PLLRST**: `pll_rst`=1, `sys_rst_n`=0. At `cnt==PLL_RST_CYCLES-1`, go to WAIT.
  - **WAIT**: `pll_rst`=0, `sys_rst_n`=0.
    - If `locked_s`=1, go to SETTLE.
    - Else, at `cnt==LOCK_TIMEOUT-1`: if `retries==MAX_RETRIES`, go to FAIL; otherwise increment `retries` and go to PLLRST.
  - **SETTLE**: `sys_rst_n`=0.
    - If `locked_s`=0, return to WAIT. The WAIT timeout restarts and `retries` is unchanged.
    - At `cnt==LOCK_STABLE_CYCLES-1` with `locked_s`=1, go to RUN and clear `retries`.
  - **RUN**: `sys_rst_n`=1, `ready`=1.
    - If `locked_s`=0, go to PLLRST. `sys_rst_n` drops at that same edge, and `loss_cnt` increments, saturating at 255.
  - **FAIL**: `pll_rst`=0, `sys_rst_n`=0, `fail`=1. Terminal; the only exit is `rst_n`.
- All outputs are registered and decoded from the next state, so each output changes at the same edge as the state transition.
- Reset values (`rst_n` low, asynchronous):
  - State = PLLRST, `cnt`=0, `retries`=0, synchronizer flops = 0.
  - Outputs: `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0, `loss_cnt`=0.
- Reset mid-operation: any state, including FAIL, returns immediately to the reset values. `loss_cnt` is cleared.

## Timing
- `pll_rst` is high for exactly `PLL_RST_CYCLES` rising edges after `rst_n` deasserts, and exactly that long on each retry or relock.
- Lock-input latency: a `pll_locked` rise is visible as `locked_s` after 2 edges.
- Release: `sys_rst_n` rises `LOCK_STABLE_CYCLES` edges after the edge at which WAIT first samples `locked_s`=1.
- Lock loss: `sys_rst_n` and `ready` fall at the first edge that samples `locked_s`=0 in RUN, which is 3 edges after `pll_locked` falls. `pll_rst` rises at that same edge.
- A `locked_s` glitch lasting 1 cycle in SETTLE restarts the full settle period. No partial credit.
- FAIL entry is deterministic: `(MAX_RETRIES+1)` timeouts with no lock, `fail` rising at the last timeout edge.
- `sys_rst_n` never rises while `pll_rst`=1 or `locked_s`=0.

## Structure
- Package `pll_reset_seq_pkg`: state enum (PLLRST, WAIT, SETTLE, RUN, FAIL) and default parameter constants.
- Sub-module `sync2`: 2-flop synchronizer with async active-low reset (clear to 0).
- No other hierarchy.

## Test plan
All scenarios use `LOCK_STABLE_CYCLES`=8, `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `MAX_RETRIES`=2.

- **Clean bring-up.** Release `rst_n`, then raise `pll_locked` 10 cycles later.
  - `pll_rst` is high for 4 edges.
  - `sys_rst_n` and `ready` rise 8 edges after WAIT sees `locked_s`; `loss_cnt`=0.
- **Settle glitch.** Drop `pll_locked` for 1 cycle at settle cycle 5.
  - `sys_rst_n` stays 0.
  - The settle count restarts; release occurs 8 edges after re-lock is seen.
- **Lock loss in RUN.** Drop `pll_locked` while in RUN.
  - `sys_rst_n` falls 3 edges later, with `pll_rst`=1 at that same edge, held for 4 cycles.
  - `loss_cnt`=1; re-lock → RUN.
- **Timeout retries.** Hold `pll_locked`=0 throughout.
  - Exactly 3 WAIT timeouts of 32 cycles each, separated by 4-cycle `pll_rst` pulses.
  - Then `fail`=1 and `pll_rst`=0; `fail` stays high even if `pll_locked` later rises.
- **Saturation.** Cause 260 lock losses.
  - `loss_cnt`=255 and stays there.
- **Async reset from RUN or FAIL.** Pulse `rst_n` low mid-cycle.
  - All outputs take their reset values immediately, before the next edge: `pll_rst`=1, `loss_cnt`=0, `fail`=0.

Source files
------------

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and default timing constants for the PLL reset/lock supervisor.
package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_PLL_RST_CYCLES     = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT       = 65536;
    localparam int unsigned DEF_MAX_RETRIES        = 3;
    localparam int unsigned LOSS_CNT_W             = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises PLL reset and lock; releases the system reset only after lock
// has been continuously stable, retries on timeout and latches a failure.
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int unsigned MAX_RETRIES        = DEF_MAX_RETRIES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  fail,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    localparam int unsigned CNT_MAX = max3(LOCK_STABLE_CYCLES, PLL_RST_CYCLES, LOCK_TIMEOUT);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RET_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_LIMIT   = RET_W'(MAX_RETRIES);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RET_W-1:0]      retries_q, retries_d;
    logic [LOSS_CNT_W-1:0] loss_d;
    logic                  locked_s;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Next-state, shared cycle counter, retry and loss bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retries_d = retries_q;
        loss_d    = loss_cnt;

        case (state_q)
            ST_PLLRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (locked_s) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == TMO_LAST) begin
                    if (retries_q == RET_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        retries_d = retries_q + RET_W'(1);
                        state_d   = ST_PLLRST;
                    end
                end
            end
            ST_SETTLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = ST_RUN;
                    retries_d = '0;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_PLLRST;
                    if (loss_cnt != {LOSS_CNT_W{1'b1}}) begin
                        loss_d = loss_cnt + LOSS_CNT_W'(1);
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLLRST;
            end
        endcase

        // Counter is unused in RUN/FAIL, so hold it there instead of wrapping.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_RUN || state_q == ST_FAIL) begin
            cnt_d = cnt_q;
        end
    end

    // State, counters and outputs; outputs decode the next state so they move with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_PLLRST;
            cnt_q     <= '0;
            retries_q <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            loss_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            pll_rst   <= (state_d == ST_PLLRST);
            sys_rst_n <= (state_d == ST_RUN);
            ready     <= (state_d == ST_RUN);
            fail      <= (state_d == ST_FAIL);
            loss_cnt  <= loss_d;
        end
    end

endmodule
